// File: rtl/spi_cmd_dispatcher.sv
// Queues completed SPI write frames and forwards them to user-area modules over req/ack.
// Define SPI_DISP_ERR_COUNT_EN to add 8-bit saturating drop/timeout counters to the status word.
module spi_cmd_dispatcher #(
    parameter int NUM_MODULES    = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              i_SYSCLK,
    input  logic                              i_RST,
    input  logic [6:0]                        i_ADDR,
    input  logic [DATA_WIDTH-1:0]             i_DATA_IN,
    input  logic                              i_DIN_VALID,
    output logic [DATA_WIDTH-1:0]             o_SPI_RDATA,
    output logic [NUM_MODULES-1:0]            o_WR_REQ,
    output logic [3:0]                        o_WR_REG,
    output logic [DATA_WIDTH-1:0]             o_WR_DATA,
    input  logic [NUM_MODULES-1:0]            i_WR_ACK,
    input  logic [NUM_MODULES*DATA_WIDTH-1:0] i_RD_DATA,
    output logic                              o_BUSY,
    output logic                              o_DROP,
    output logic                              o_TIMEOUT
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = DATA_WIDTH + 7;
    localparam logic [3:0]             NM_C      = 4'(NUM_MODULES);
    localparam logic [CW-1:0]          DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0]          TMO_C     = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]             STATUS_ID = 3'd7;
    localparam logic [NUM_MODULES-1:0] ONE_HOT_0 = NUM_MODULES'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_GAP = 2'd2} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [EW-1:0]           r_fifo [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_nxt;
    logic [NUM_MODULES-1:0]  r_sel;
    logic [TW-1:0]           r_tcnt;
    logic [NUM_MODULES-1:0]  r_wr_req;
    logic [NUM_MODULES-1:0]  w_req_nxt;
    logic [3:0]              r_wr_reg;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    r_drop;
    logic                    r_timeout;
    logic                    r_drop_flag;
    logic                    r_to_flag;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [DATA_WIDTH-1:0]   w_status;
    logic [1:0]              w_cnt_sat;
`ifdef SPI_DISP_ERR_COUNT_EN
    logic [7:0]              r_drop_cnt;
    logic [7:0]              r_to_cnt;
`endif

    logic [EW-1:0]           w_head;
    logic [2:0]              w_head_id;
    logic [3:0]              w_head_reg;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_start;
    logic                    w_clr;
    logic                    w_ack_hit;
    logic                    w_to_evt;

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_id   = w_head[DATA_WIDTH+2:DATA_WIDTH];
    assign w_head_reg  = w_head[DATA_WIDTH+6:DATA_WIDTH+3];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts while IDLE drains it.
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
    assign w_push    = i_DIN_VALID && ((r_count < DEPTH_C) || w_pop);
    assign w_drop    = i_DIN_VALID && !w_push;
    assign w_start   = w_pop && ({1'b0, w_head_id} < NM_C);
    assign w_clr     = w_pop && (w_head_id == STATUS_ID) && (w_head_reg == 4'd0) && w_head_data[0];
    assign w_ack_hit = |(i_WR_ACK & r_sel);
    assign w_to_evt  = (r_state == ST_REQ) && !w_ack_hit && (r_tcnt == TMO_C);

    // FSM state register
    always_ff @(posedge i_SYSCLK) begin
        if (i_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_ack_hit || w_to_evt) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so every port is a flop
    always_comb begin
        w_req_nxt  = '0;
        w_busy_nxt = (w_count_nxt != '0) || (w_state_nxt != ST_IDLE);
        if ((r_state == ST_REQ) && !w_ack_hit && !w_to_evt) begin
            w_req_nxt = r_sel;
        end else begin
            w_req_nxt = '0;
        end
    end

    // FIFO occupancy next value
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Command FIFO storage and pointers
    always_ff @(posedge i_SYSCLK) begin
        if (i_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {i_ADDR, i_DATA_IN};
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Active command and ack timeout counter; reg/data persist after completion
    always_ff @(posedge i_SYSCLK) begin
        if (i_RST) begin
            r_sel     <= '0;
            r_wr_reg  <= 4'd0;
            r_wr_data <= '0;
            r_tcnt    <= '0;
        end else if (w_start) begin
            r_sel     <= ONE_HOT_0 << w_head_id;
            r_wr_reg  <= w_head_reg;
            r_wr_data <= w_head_data;
            r_tcnt    <= '0;
        end else if (r_state == ST_REQ) begin
            r_tcnt <= r_tcnt + TW'(1);
        end else begin
            r_tcnt <= r_tcnt;
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge i_SYSCLK) begin
        if (i_RST) begin
            r_drop_flag <= 1'b0;
            r_to_flag   <= 1'b0;
        end else begin
            r_drop_flag <= w_drop   | (r_drop_flag & ~w_clr);
            r_to_flag   <= w_to_evt | (r_to_flag & ~w_clr);
        end
    end

`ifdef SPI_DISP_ERR_COUNT_EN
    // Saturating error counters
    always_ff @(posedge i_SYSCLK) begin
        if (i_RST) begin
            r_drop_cnt <= 8'd0;
            r_to_cnt   <= 8'd0;
        end else begin
            if (w_drop) begin
                r_drop_cnt <= w_clr ? 8'd1 : ((r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1);
            end else if (w_clr) begin
                r_drop_cnt <= 8'd0;
            end
            if (w_to_evt) begin
                r_to_cnt <= w_clr ? 8'd1 : ((r_to_cnt == 8'hFF) ? 8'hFF : r_to_cnt + 8'd1);
            end else if (w_clr) begin
                r_to_cnt <= 8'd0;
            end
        end
    end
`endif

    assign w_cnt_sat = (r_count > CW'(3)) ? 2'd3 : r_count[1:0];

    // Status word assembly
    always_comb begin
        w_status      = '0;
        w_status[0]   = r_drop_flag;
        w_status[1]   = r_to_flag;
        w_status[2]   = r_busy;
        w_status[5:4] = w_cnt_sat;
`ifdef SPI_DISP_ERR_COUNT_EN
        w_status[15:8]  = r_drop_cnt;
        w_status[23:16] = r_to_cnt;
`endif
    end

    // Read-data mux; IDs without a module return zero
    always_comb begin
        w_rdata = '0;
        if (i_ADDR[2:0] == STATUS_ID) begin
            w_rdata = w_status;
        end else begin
            for (int k = 0; k < NUM_MODULES; k++) begin
                w_rdata = w_rdata | ((i_ADDR[2:0] == 3'(k)) ? i_RD_DATA[k*DATA_WIDTH +: DATA_WIDTH]
                                                            : {DATA_WIDTH{1'b0}});
            end
        end
    end

    // Registered outputs
    always_ff @(posedge i_SYSCLK) begin
        if (i_RST) begin
            r_wr_req  <= '0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_wr_req  <= w_req_nxt;
            r_busy    <= w_busy_nxt;
            r_drop    <= w_drop;
            r_timeout <= w_to_evt;
            r_rdata   <= w_rdata;
        end
    end

    assign o_WR_REQ    = r_wr_req;
    assign o_WR_REG    = r_wr_reg;
    assign o_WR_DATA   = r_wr_data;
    assign o_BUSY      = r_busy;
    assign o_DROP      = r_drop;
    assign o_TIMEOUT   = r_timeout;
    assign o_SPI_RDATA = r_rdata;

endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
// Scoreboard bench for spi_cmd_dispatcher: expected requests queued at stimulus time and
// compared when the DUT raises o_WR_REQ; an auto-responder supplies acks.
module tb_spi_cmd_dispatcher;
    localparam int NM = 4;
    localparam int DW = 32;
    localparam int FD = 2;
    localparam int TO = 40;
`ifdef SPI_DISP_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       addr;
    logic [DW-1:0]    din;
    logic             valid;
    logic [DW-1:0]    spi_rdata;
    logic [NM-1:0]    wr_req;
    logic [3:0]       wr_reg;
    logic [DW-1:0]    wr_data;
    logic [NM-1:0]    wr_ack;
    logic [NM*DW-1:0] rd_data;
    logic             busy;
    logic             drop;
    logic             tmo;

    logic [NM-1:0]    ack_resp;
    logic [NM-1:0]    other_ack;
    assign wr_ack = ack_resp | other_ack;

    typedef struct packed {
        logic [NM-1:0] sel;
        logic [3:0]    rg;
        logic [31:0]   data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ack_en = 0;
    int ack_delay = 0;
    int exp_hi_len = 0;
    bit exp_to = 1'b0;
    int to_pulses = 0;
    int drop_pulses = 0;

    always #5 clk = ~clk;

    spi_cmd_dispatcher #(
        .NUM_MODULES(NM), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_SYSCLK(clk), .i_RST(rst), .i_ADDR(addr), .i_DATA_IN(din), .i_DIN_VALID(valid),
        .o_SPI_RDATA(spi_rdata), .o_WR_REQ(wr_req), .o_WR_REG(wr_reg), .o_WR_DATA(wr_data),
        .i_WR_ACK(wr_ack), .i_RD_DATA(rd_data), .o_BUSY(busy), .o_DROP(drop), .o_TIMEOUT(tmo)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input logic df, input logic tf, input logic bz,
                                         input logic [1:0] cnt, input logic [7:0] dc,
                                         input logic [7:0] tc);
        logic [31:0] s;
        s = 32'd0;
        s[0] = df;
        s[1] = tf;
        s[2] = bz;
        s[5:4] = cnt;
        if (CNT_EN) begin
            s[15:8]  = dc;
            s[23:16] = tc;
        end
        return s;
    endfunction

    // Drive one frame for one cycle; queue the expected request if it should reach a module.
    task automatic send(input logic [3:0] rg, input logic [2:0] id, input logic [31:0] d,
                        input bit accept);
        logic [NM-1:0] one;
        one = 4'b0001;
        addr  = {rg, id};
        din   = d;
        valid = 1'b1;
        if (accept && (int'(id) < NM)) begin
            exp_q.push_back({one << id, rg, d});
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] s);
        addr = 7'd7;
        @(negedge clk);
        s = spi_rdata;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && (wr_req == '0)) break;
        end
        check_val("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_req_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_req == '0) break;
        end
        check_val("req_low_wait", 32'(wr_req), 32'd0);
    endtask

    task automatic wait_req_high(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_req != '0) break;
        end
        check_val("req_high_wait", 32'(wr_req != '0), 32'd1);
    endtask

    // Monitor: scoreboard compare at each new request, request length, and ack responder.
    initial begin
        logic [NM-1:0] prev_req;
        int            hi_cnt;
        exp_t          e;
        prev_req = '0;
        hi_cnt   = 0;
        ack_resp = '0;
        forever begin
            @(negedge clk);
            if ((wr_req != '0) && (prev_req == '0)) begin
                if (exp_q.size() == 0) begin
                    check_val("unexp_req", 32'(wr_req), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("req_sel", 32'(wr_req), 32'(e.sel));
                    check_val("req_reg", 32'(wr_reg), 32'(e.rg));
                    check_val("req_data", wr_data, e.data);
                end
                hi_cnt = 1;
            end else if (wr_req != '0) begin
                hi_cnt = hi_cnt + 1;
            end
            if ((wr_req == '0) && (prev_req != '0) && (exp_hi_len != 0)) begin
                check_val("req_len", 32'(hi_cnt), 32'(exp_hi_len));
                check_val("to_at_end", 32'(tmo), 32'(exp_to));
            end
            if (tmo) to_pulses++;
            if (drop) drop_pulses++;
            ack_resp = '0;
            if ((wr_req != '0) && (ack_en != 0) && (hi_cnt >= ack_delay)) begin
                ack_resp = wr_req;
            end
            prev_req = wr_req;
        end
    end

    initial begin
        logic [31:0] s;
        rst = 1'b1; addr = 7'd0; din = '0; valid = 1'b0; rd_data = '0; other_ack = '0;
        repeat (3) @(negedge clk);
        check_val("rst_req", 32'(wr_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_drop", 32'(drop), 32'd0);
        check_val("rst_tmo", 32'(tmo), 32'd0);
        check_val("rst_rdata", spi_rdata, 32'd0);
        check_val("rst_wreg", 32'(wr_reg), 32'd0);
        check_val("rst_wdata", wr_data, 32'd0);
        rst = 1'b0;
        read_status(s);
        check_val("rst_status", s, 32'd0);

        // Single write with ack three cycles after req
        ack_en = 1; ack_delay = 3; exp_hi_len = 3; exp_to = 1'b0;
        send(4'd5, 3'd2, 32'hDEADBEEF, 1'b1);
        check_val("lat_n0", 32'(wr_req), 32'd0);
        @(negedge clk);
        check_val("lat_n1", 32'(wr_req), 32'd0);
        check_val("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("lat_n2", 32'(wr_req), 32'h4);
        check_val("lat_reg", 32'(wr_reg), 32'd5);
        check_val("lat_data", wr_data, 32'hDEADBEEF);
        wait_req_low(20);
        check_val("gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("busy_fall", 32'(busy), 32'd0);
        check_val("reg_hold", 32'(wr_reg), 32'd5);
        check_val("data_hold", wr_data, 32'hDEADBEEF);

        // Overflow: one request outstanding, three more frames, third is dropped
        ack_en = 0; exp_hi_len = 0;
        send(4'd1, 3'd0, 32'h1111_0000, 1'b1);
        wait_req_high(10);
        send(4'd2, 3'd1, 32'hAAAA_0001, 1'b1);
        send(4'd3, 3'd3, 32'hAAAA_0002, 1'b1);
        send(4'd4, 3'd2, 32'hAAAA_0003, 1'b0);
        check_val("drop_pulse", 32'(drop), 32'd1);
        read_status(s);
        check_val("stat_drop", s, stat(1'b1, 1'b0, 1'b1, 2'd2, 8'd1, 8'd0));
        check_val("drop_clear", 32'(drop), 32'd0);
        ack_en = 1; ack_delay = 2;
        wait_idle(100);
        check_val("q_empty", 32'(exp_q.size()), 32'd0);
        check_val("drop_pulses", 32'(drop_pulses), 32'd1);

        // Timeout with acks from non-selected modules present
        ack_en = 0; other_ack = 4'b1001; exp_hi_len = TO; exp_to = 1'b1;
        send(4'd9, 3'd1, 32'h0BAD_F00D, 1'b1);
        wait_idle(200);
        other_ack = '0; exp_hi_len = 0; exp_to = 1'b0;
        check_val("to_pulses", 32'(to_pulses), 32'd1);
        read_status(s);
        check_val("stat_to", s, stat(1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 8'd1));

        // Status writes: other register and bit0=0 ignored, then clear; unserved ID discarded
        send(4'd3, 3'd7, 32'h1, 1'b0);
        wait_idle(20);
        send(4'd0, 3'd7, 32'h2, 1'b0);
        wait_idle(20);
        read_status(s);
        check_val("stat_ignored", s, stat(1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 8'd1));
        send(4'd0, 3'd7, 32'h1, 1'b0);
        wait_idle(20);
        read_status(s);
        check_val("stat_clr", s, 32'd0);
        send(4'd2, 3'd5, 32'hFFFF_FFFF, 1'b1);
        wait_idle(20);
        repeat (3) @(negedge clk);
        check_val("id5_noreq", 32'(wr_req), 32'd0);
        read_status(s);
        check_val("stat_id5", s, 32'd0);

        // Read mux
        rd_data[0*DW +: DW] = 32'hA0A0_5555;
        rd_data[1*DW +: DW] = 32'h1111_2222;
        rd_data[3*DW +: DW] = 32'h1234_5678;
        addr = {4'd9, 3'd0};
        @(negedge clk);
        check_val("rd_m0", spi_rdata, 32'hA0A0_5555);
        addr = 7'd3;
        check_val("rd_lat", spi_rdata, 32'hA0A0_5555);
        @(negedge clk);
        check_val("rd_m3", spi_rdata, 32'h1234_5678);
        addr = 7'd6;
        @(negedge clk);
        check_val("rd_id6", spi_rdata, 32'd0);
        addr = 7'd1;
        @(negedge clk);
        check_val("rd_m1", spi_rdata, 32'h1111_2222);

        // Reset while a request is active and another frame is queued
        ack_en = 0;
        send(4'd6, 3'd2, 32'hCAFE_0001, 1'b1);
        send(4'd7, 3'd3, 32'hCAFE_0002, 1'b1);
        wait_req_high(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_val("mrst_req", 32'(wr_req), 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_reg", 32'(wr_reg), 32'd0);
        other_ack = 4'b0100;
        repeat (4) @(negedge clk);
        other_ack = '0;
        check_val("mrst_req2", 32'(wr_req), 32'd0);
        check_val("mrst_busy2", 32'(busy), 32'd0);
        read_status(s);
        check_val("mrst_stat", s, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
